// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round sequencer.
//   state_t      : round state encoding (4-bit, exported on state_o)
//   NATURAL_MIN  : two-card total that ends the deal as a natural
//   PLAYER_STAND_MIN : lowest two-card player total that stands
//   card_value() : rank (0 = none, 1..13 = A..K) to baccarat value 0..9
package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        P1      = 4'd1,
        D1      = 4'd2,
        P2      = 4'd3,
        D2      = 4'd4,
        EVAL    = 4'd5,
        DRAW_P3 = 4'd6,
        EVAL_P3 = 4'd7,
        DRAW_D3 = 4'd8,
        RESULT  = 4'd9,
        DONE    = 4'd10
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;

    // Tens and faces count zero, as does "no card".
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        if (rank >= 4'd1 && rank <= 4'd9) begin
            return rank;
        end
        return 4'd0;
    endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// Banker third-card table, used once the player has drawn a third card.
//   dscore : dealer two-card score
//   v      : value (0..9) of the player's third card
//   draw   : 1 when the dealer must take a third card
module dealer_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/round_controller.sv
// Baccarat round sequencer: deals four cards, applies natural / player /
// banker drawing rules, then latches the winner onto the lights.
//   slow_clock, resetb        : clock and synchronous active-low reset
//   pscore, dscore, pcard3    : hand scores and player third card from datapath
//   load_pcard1..load_dcard3  : one-cycle card-load strobes (Moore)
//   player_win_light, dealer_win_light, round_done : result, valid in DONE
//   state_o                   : current state encoding
module round_controller
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       round_done,
    output logic [3:0] state_o
);

    state_t     state;
    state_t     next_state;
    logic       player_win_q;
    logic       dealer_win_q;
    logic [3:0] p3_value;
    logic       dealer_draw;

    assign p3_value = card_value(pcard3);

    dealer_draw_rule u_dealer_draw_rule (
        .dscore (dscore),
        .v      (p3_value),
        .draw   (dealer_draw)
    );

    // State register.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = P1;
            P1:      next_state = D1;
            D1:      next_state = P2;
            P2:      next_state = D2;
            D2:      next_state = EVAL;
            EVAL: begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) begin
                    next_state = RESULT;
                end else if (pscore < PLAYER_STAND_MIN) begin
                    next_state = DRAW_P3;
                end else if (dscore < PLAYER_STAND_MIN) begin
                    // Player stood on 6/7: dealer draws on 0..5.
                    next_state = DRAW_D3;
                end else begin
                    next_state = RESULT;
                end
            end
            DRAW_P3: next_state = EVAL_P3;
            EVAL_P3: next_state = dealer_draw ? DRAW_D3 : RESULT;
            DRAW_D3: next_state = RESULT;
            RESULT:  next_state = DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Winner flops, captured on the edge leaving RESULT.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            player_win_q <= 1'b0;
            dealer_win_q <= 1'b0;
        end else if (state == RESULT) begin
            player_win_q <= (pscore >= dscore);
            dealer_win_q <= (dscore >= pscore);
        end
    end

    // Moore output decode.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        round_done       = 1'b0;
        state_o          = state;
        case (state)
            P1:      load_pcard1 = 1'b1;
            D1:      load_dcard1 = 1'b1;
            P2:      load_pcard2 = 1'b1;
            D2:      load_dcard2 = 1'b1;
            DRAW_P3: load_pcard3 = 1'b1;
            DRAW_D3: load_dcard3 = 1'b1;
            DONE: begin
                player_win_light = player_win_q;
                dealer_win_light = dealer_win_q;
                round_done       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: table of full rounds with a bench-side
// datapath that updates the scores on the third-card strobes, a reset-mid-round
// sequence, and an exhaustive sweep of the banker table.
module tb_round_controller;
    import baccarat_pkg::*;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pscore     = 4'd0;
    logic [3:0] dscore     = 4'd0;
    logic [3:0] pcard3     = 4'd0;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, round_done;
    logic [3:0] state_o;

    logic [3:0] rule_d;
    logic [3:0] rule_v;
    logic       rule_draw;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 slow_clock = ~slow_clock;

    round_controller dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .round_done       (round_done),
        .state_o          (state_o)
    );

    dealer_draw_rule u_rule (
        .dscore (rule_d),
        .v      (rule_v),
        .draw   (rule_draw)
    );

    typedef struct {
        string      name;
        logic [3:0] p_init;
        logic [3:0] d_init;
        logic [3:0] card3;
        logic [3:0] p_final;
        logic [3:0] d_final;
        int         p3_cyc;   // cycle load_pcard3 is high, 0 = never
        int         d3_cyc;   // cycle load_dcard3 is high, 0 = never
        int         done_cyc;
        logic       exp_pl;
        logic       exp_dl;
    } round_t;

    round_t rounds[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    task automatic hold_reset();
        @(negedge slow_clock);
        resetb = 1'b0;
        cycle();
        resetb = 1'b1;
    endtask

    task automatic run_round(input round_t r);
        logic [5:0] open_exp [4];
        logic [5:0] strb;
        int n_p3, n_d3, p3_at, d3_at, done_at, early_light, open_bad;
        open_exp[0] = 6'b100000;
        open_exp[1] = 6'b010000;
        open_exp[2] = 6'b001000;
        open_exp[3] = 6'b000100;
        n_p3 = 0; n_d3 = 0; p3_at = 0; d3_at = 0;
        done_at = 0; early_light = 0; open_bad = 0;
        pscore = r.p_init;
        dscore = r.d_init;
        pcard3 = r.card3;
        hold_reset();
        for (int cyc = 1; cyc <= 14; cyc++) begin
            cycle();
            strb = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                    load_pcard3, load_dcard3};
            if (cyc <= 4 && strb != open_exp[cyc-1]) open_bad++;
            if (load_pcard3) begin
                n_p3++;
                if (p3_at == 0) p3_at = cyc;
                pscore = r.p_final;
            end
            if (load_dcard3) begin
                n_d3++;
                if (d3_at == 0) d3_at = cyc;
                dscore = r.d_final;
            end
            if (!round_done && (player_win_light || dealer_win_light)) early_light++;
            if (round_done && done_at == 0) done_at = cyc;
        end
        check({r.name, " opening strobes"}, open_bad, 0);
        check({r.name, " pcard3 cycle"}, p3_at, r.p3_cyc);
        check({r.name, " pcard3 count"}, n_p3, (r.p3_cyc != 0) ? 1 : 0);
        check({r.name, " dcard3 cycle"}, d3_at, r.d3_cyc);
        check({r.name, " dcard3 count"}, n_d3, (r.d3_cyc != 0) ? 1 : 0);
        check({r.name, " done cycle"}, done_at, r.done_cyc);
        check({r.name, " lights before done"}, early_light, 0);
        check({r.name, " player light"}, int'(player_win_light), int'(r.exp_pl));
        check({r.name, " dealer light"}, int'(dealer_win_light), int'(r.exp_dl));
        check({r.name, " state absorbing"}, int'(state_o), 10);
    endtask

    initial begin
        logic [9:0] banker [8];
        logic [9:0] row;

        //            name        pi     di     c3     pf     df    p3 d3 done pl    dl
        rounds[0] = '{"natural",   4'd8,  4'd3,  4'd0,  4'd8,  4'd3,  0, 0,  7, 1'b1, 1'b0};
        rounds[1] = '{"p_draw",    4'd4,  4'd6,  4'd13, 4'd4,  4'd6,  6, 0,  9, 1'b0, 1'b1};
        rounds[2] = '{"both_tie",  4'd2,  4'd5,  4'd5,  4'd7,  4'd7,  6, 8, 10, 1'b1, 1'b1};
        rounds[3] = '{"d_only",    4'd7,  4'd4,  4'd0,  4'd7,  4'd9,  0, 6,  8, 1'b0, 1'b1};
        rounds[4] = '{"d_natural", 4'd3,  4'd9,  4'd0,  4'd3,  4'd9,  0, 0,  7, 1'b0, 1'b1};
        rounds[5] = '{"stand_tie", 4'd6,  4'd6,  4'd0,  4'd6,  4'd6,  0, 0,  7, 1'b1, 1'b1};
        rounds[6] = '{"d3_v8",     4'd0,  4'd3,  4'd8,  4'd8,  4'd3,  6, 0,  9, 1'b1, 1'b0};
        rounds[7] = '{"d2_ten",    4'd5,  4'd2,  4'd10, 4'd5,  4'd1,  6, 8, 10, 1'b1, 1'b0};
        rounds[8] = '{"raw_12",    4'd12, 4'd3,  4'd0,  4'd12, 4'd3,  0, 0,  7, 1'b1, 1'b0};

        // Banker table, bit v set when the dealer draws.
        banker[0] = 10'b11_1111_1111;
        banker[1] = 10'b11_1111_1111;
        banker[2] = 10'b11_1111_1111;
        banker[3] = 10'b10_1111_1111;
        banker[4] = 10'b00_1111_1100;
        banker[5] = 10'b00_1111_0000;
        banker[6] = 10'b00_1100_0000;
        banker[7] = 10'b00_0000_0000;

        // Reset state.
        hold_reset();
        resetb = 1'b0;
        cycle();
        check("reset state", int'(state_o), 0);
        check("reset strobes", int'({load_pcard1, load_pcard2, load_pcard3,
                                     load_dcard1, load_dcard2, load_dcard3}), 0);
        check("reset lights", int'({player_win_light, dealer_win_light, round_done}), 0);

        for (int i = 0; i < 9; i++) run_round(rounds[i]);

        // Reset asserted while in DRAW_P3.
        pscore = 4'd4; dscore = 4'd6; pcard3 = 4'd13;
        hold_reset();
        for (int cyc = 1; cyc <= 6; cyc++) cycle();
        check("mid reset in DRAW_P3", int'(load_pcard3), 1);
        resetb = 1'b0;
        cycle();
        check("mid reset state", int'(state_o), 0);
        check("mid reset strobes", int'({load_pcard1, load_pcard2, load_pcard3,
                                         load_dcard1, load_dcard2, load_dcard3}), 0);
        check("mid reset lights", int'({player_win_light, dealer_win_light, round_done}), 0);
        resetb = 1'b1;
        cycle();
        check("restart pcard1", int'(load_pcard1), 1);
        check("restart state", int'(state_o), 1);

        // Reset from DONE clears the lights.
        pscore = 4'd9; dscore = 4'd9;
        for (int cyc = 2; cyc <= 8; cyc++) cycle();
        check("tie done lights", int'({player_win_light, dealer_win_light, round_done}), 7);
        resetb = 1'b0;
        cycle();
        check("done reset lights", int'({player_win_light, dealer_win_light, round_done}), 0);
        resetb = 1'b1;

        // Exhaustive banker table.
        for (int d = 0; d < 8; d++) begin
            row = banker[d];
            for (int v = 0; v < 10; v++) begin
                rule_d = 4'(d);
                rule_v = 4'(v);
                #1;
                check($sformatf("banker d=%0d v=%0d", d, v), int'(rule_draw), int'(row[v]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Baccarat round sequencer. It drives the six card-load strobes of the hand datapath and consumes that datapath's player score, dealer score and player third card.
- Deals the four opening cards, then applies the natural, player third-card and dealer third-card rules. Latches the winner onto two lights.
- Runs on the same slow clock as the hand registers, so every load strobe is sampled by the datapath on the edge that leaves the strobing state.

Parameters:
none

Ports:
slow_clock  input  1  round clock; the same edge loads the datapath card registers
resetb  input  1  synchronous active-low reset, sampled on rising slow_clock
pscore  input  4  player hand score 0..9, from datapath
dscore  input  4  dealer hand score 0..9, from datapath
pcard3  input  4  player third card rank; 0 = none, 1..13 = A..K
load_pcard1  output  1  load player card 1
load_pcard2  output  1  load player card 2
load_pcard3  output  1  load player card 3
load_dcard1  output  1  load dealer card 1
load_dcard2  output  1  load dealer card 2
load_dcard3  output  1  load dealer card 3
player_win_light  output  1  player won, or tie
dealer_win_light  output  1  dealer won, or tie
round_done  output  1  round complete; lights valid
state_o  output  4  current state encoding, for debug/bench

Behaviour:
- Reset: resetb sampled low on a rising slow_clock forces state IDLE. Winner flops clear to 0. All outputs are 0 in IDLE.
- Reset mid-round: from any state, resetb low returns to IDLE on that edge, with no further strobes. This matches the datapath clearing its cards on the same edge.
- Load strobes are Moore decodes of the state. Exactly one strobe is high in each DEAL/DRAW state; none in any other state.
- States, each lasting one cycle except DONE:
  - IDLE -> P1 (load_pcard1) -> D1 (load_dcard1) -> P2 (load_pcard2) -> D2 (load_dcard2) -> EVAL.
  - EVAL: scores reflect four cards.
    - pscore>=8 or dscore>=8 (natural) -> RESULT.
    - else pscore<=5 -> DRAW_P3.
    - else (pscore 6..7) -> dscore<=5 ? DRAW_D3 : RESULT.
  - DRAW_P3 (load_pcard3) -> EVAL_P3. pcard3 and pscore are now final.
  - EVAL_P3: derive v = card value of pcard3: ranks 1..9 give the rank; ranks 10..13 give 0.
    - Dealer draws when dscore<=2.
    - dscore=3: v!=8.
    - dscore=4: v in 2..7.
    - dscore=5: v in 4..7.
    - dscore=6: v in 6..7.
    - dscore=7: never.
    - Draw -> DRAW_D3, else -> RESULT.
  - DRAW_D3 (load_dcard3) -> RESULT.
  - RESULT: compare final scores; on the exiting edge latch the winner flops.
    - pscore>dscore: player=1, dealer=0.
    - pscore<dscore: player=0, dealer=1.
    - equal: both 1.
    - Then -> DONE.
  - DONE: lights driven from the winner flops; round_done=1. Absorbing; only resetb leaves it.
- Latency after reset release, counting cycles from the first edge with resetb=1:
  - natural: RESULT is cycle 6; lights high from cycle 7.
  - player draws, dealer stands: lights from cycle 9.
  - both draw: lights from cycle 10.
  - player stands, dealer draws: lights from cycle 8.
- Input rules:
  - pscore/dscore values above 9 are treated as their raw value in comparisons; no saturation is applied.
  - pcard3 is read only in EVAL_P3.
  - pcard3=0 in EVAL_P3 gives v=0.
- Light outputs are registered; no combinational path from the score inputs to the lights.

Decomposition:
- Package baccarat_pkg holds:
  - state enum (IDLE, P1, D1, P2, D2, EVAL, DRAW_P3, EVAL_P3, DRAW_D3, RESULT, DONE), 4-bit;
  - constant NATURAL_MIN=8;
  - constant PLAYER_STAND_MIN=6;
  - function card_value(rank) returning 0..9.
- One combinational sub-module, dealer_draw_rule, with inputs dscore and v and output draw. It isolates the banker table for exhaustive unit test.

Test Plan:
- Natural: pscore=8, dscore=3 at EVAL -> no load_pcard3/load_dcard3 ever.
  - Cycle 7: player_win_light=1, dealer_win_light=0, round_done=1.
- Player draws, dealer stands: pscore=4, dscore=6; pcard3=13 (v=0); final pscore=4.
  - load_pcard3 pulses once; load_dcard3 never.
  - DONE: dealer light only.
- Both draw, tie: pscore=2, dscore=5; pcard3=5 (v=5); final pscore=7, dscore=7.
  - load_pcard3 then load_dcard3 in consecutive states.
  - Both lights 1.
- Player stands, dealer draws: pscore=7, dscore=4 -> DRAW_D3 directly after EVAL.
  - Final dscore=9 -> dealer light.
- Banker table sweep via dealer_draw_rule: dscore 0..7 × v 0..9 (80 cases) against the golden table.
  - Edge cases: (3,8)->0, (4,1)->0, (6,7)->1, (7,6)->0.
- Reset mid-round: resetb low during DRAW_P3.
  - Next edge: state IDLE, all strobes and lights 0.
  - Release: sequence restarts with load_pcard1 one cycle after IDLE.
